fifo_serial_link_tx_wrapper: RTL and testbench



---
 rtl/fifo_serial_link_tx_wrapper.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_fifo_serial_link_tx_wrapper.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_serial_link_tx_wrapper.sv
`default_nettype none

// ============================================================================
// Package : fifo_serial_link_tx_wrapper_pkg
// Brief   : Default AXI4 channel and request/response structs for the
//           serial-link TX wrapper (32-bit address and data, 4-bit ID).
// Revision: 1.0 - initial release
// ============================================================================
package fifo_serial_link_tx_wrapper_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic        user;
    } axi_aw_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic        user;
    } axi_ar_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic        user;
    } axi_w_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        user;
    } axi_b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        user;
    } axi_r_chan_t;

    typedef struct packed {
        axi_aw_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_t;

    typedef struct packed {
        logic         aw_ready;
        logic         ar_ready;
        logic         w_ready;
        logic         b_valid;
        axi_b_chan_t  b;
        logic         r_valid;
        axi_r_chan_t  r;
    } axi_rsp_t;

endpackage

// ============================================================================
// Module  : fifo_serial_link_tx_wrapper
// Brief   : OBI slave pushes 32-bit words into a FIFO; an AXI4 master FSM
//           drains it with one single-beat write per word to DST_ADDR. The
//           head is popped only after its B response. Exposes FIFO status
//           and a saturating count of non-OKAY write responses.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_serial_link_tx_wrapper #(
    parameter type         axi_req_t  = fifo_serial_link_tx_wrapper_pkg::axi_req_t,
    parameter type         axi_rsp_t  = fifo_serial_link_tx_wrapper_pkg::axi_rsp_t,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] DST_ADDR   = 32'h0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  testmode_i,
    input  logic                  writer_req_i,
    output logic                  writer_gnt_o,
    output logic                  writer_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] writer_addr_i,
    input  logic                  writer_we_i,
    input  logic [3:0]            writer_be_i,
    input  logic [DATA_WIDTH-1:0] writer_wdata_i,
    output logic [DATA_WIDTH-1:0] writer_rdata_o,
    output axi_req_t              reader_axi_req,
    input  axi_rsp_t              reader_axi_rsp,
    output logic                  fifo_empty_o,
    output logic                  fifo_full_o,
    output logic [7:0]            err_count_o
);

    localparam int unsigned C_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned C_CNT_W = C_PTR_W + 1;
    localparam int unsigned C_SIZE  = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                r_state;
    state_e                w_state_next;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [C_PTR_W-1:0]    r_wptr;
    logic [C_PTR_W-1:0]    r_rptr;
    logic [C_CNT_W-1:0]    r_usage;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic [7:0]            r_err_count;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_is_err_reg;
    logic                  w_gnt;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_aw_valid;
    logic                  w_w_valid;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic [7:0]            w_usage8;
    logic [DATA_WIDTH-1:0] w_status;
    logic                  w_unused;

    // FIFO flags and OBI decode; only address bit 2 selects DATA vs ERR
    assign w_empty      = (r_usage == '0);
    assign w_full       = (r_usage == C_CNT_W'(FIFO_DEPTH));
    assign w_is_err_reg = writer_addr_i[2];
    assign w_gnt        = writer_req_i & ~(writer_we_i & ~w_is_err_reg & w_full);
    assign w_push       = writer_req_i & w_gnt & writer_we_i & ~w_is_err_reg;
    assign w_pop        = (r_state == S_RESP) & reader_axi_rsp.b_valid;
    assign w_usage8     = 8'(r_usage);
    assign w_status     = {{(DATA_WIDTH-16){1'b0}}, w_usage8, 6'b0, w_full, w_empty};

    assign w_aw_valid   = (r_state == S_SEND) & ~r_aw_done;
    assign w_w_valid    = (r_state == S_SEND) & ~r_w_done;
    assign w_aw_hs      = w_aw_valid & reader_axi_rsp.aw_ready;
    assign w_w_hs       = w_w_valid & reader_axi_rsp.w_ready;

    assign writer_gnt_o    = w_gnt;
    assign writer_rvalid_o = r_rvalid;
    assign writer_rdata_o  = r_rdata;
    assign fifo_empty_o    = w_empty;
    assign fifo_full_o     = w_full;
    assign err_count_o     = r_err_count;

    // Inputs with no functional use, reduced so they are not left dangling
    assign w_unused = ^{testmode_i, writer_be_i, writer_addr_i, reader_axi_rsp};

    // FIFO storage; contents need no reset since the pointers gate validity
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= writer_wdata_i;
        end
    end

    // FIFO pointers and occupancy; push is refused at full even with a pop
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_usage <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_usage <= r_usage + 1'b1;
                2'b01:   r_usage <= r_usage - 1'b1;
                default: r_usage <= r_usage;
            endcase
        end
    end

    // OBI response: one cycle after every grant; writes return zero data
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_gnt;
            if (w_gnt && !writer_we_i) begin
                r_rdata <= w_is_err_reg ? {{(DATA_WIDTH-8){1'b0}}, r_err_count} : w_status;
            end else begin
                r_rdata <= '0;
            end
        end
    end

    // AXI FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake-done flags and saturating error counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_pop) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                if ((reader_axi_rsp.b.resp != 2'b00) && (r_err_count != 8'hFF)) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end else begin
                if (w_aw_hs) begin
                    r_aw_done <= 1'b1;
                end
                if (w_w_hs) begin
                    r_w_done <= 1'b1;
                end
            end
        end
    end

    // Next-state logic and AXI request channel outputs
    always_comb begin
        w_state_next   = r_state;
        reader_axi_req = '0;

        reader_axi_req.aw.addr  = DST_ADDR;
        reader_axi_req.aw.len   = 8'd0;
        reader_axi_req.aw.size  = 3'(C_SIZE);
        reader_axi_req.aw.burst = 2'b01;
        reader_axi_req.aw_valid = w_aw_valid;
        reader_axi_req.w.data   = r_mem[r_rptr];
        reader_axi_req.w.strb   = '1;
        reader_axi_req.w.last   = 1'b1;
        reader_axi_req.w_valid  = w_w_valid;
        reader_axi_req.b_ready  = (r_state == S_RESP);
        reader_axi_req.ar_valid = 1'b0;
        reader_axi_req.r_ready  = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (reader_axi_rsp.b_valid) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_serial_link_tx_wrapper.sv
`default_nettype none

// ============================================================================
// Module  : tb_fifo_serial_link_tx_wrapper
// Brief   : Directed self-checking bench for fifo_serial_link_tx_wrapper.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_serial_link_tx_wrapper;

    localparam logic [31:0] C_DST = 32'h1000_0040;

    logic        clk;
    logic        rst_ni;
    logic        testmode;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        empty;
    logic        full;
    logic [7:0]  err_cnt;

    fifo_serial_link_tx_wrapper_pkg::axi_req_t axi_req;
    fifo_serial_link_tx_wrapper_pkg::axi_rsp_t axi_rsp;

    int checks = 0;
    int errors = 0;
    int aw_cnt = 0;
    int w_cnt  = 0;

    fifo_serial_link_tx_wrapper #(
        .axi_req_t  (fifo_serial_link_tx_wrapper_pkg::axi_req_t),
        .axi_rsp_t  (fifo_serial_link_tx_wrapper_pkg::axi_rsp_t),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .FIFO_DEPTH (8),
        .DST_ADDR   (C_DST)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .testmode_i      (testmode),
        .writer_req_i    (req),
        .writer_gnt_o    (gnt),
        .writer_rvalid_o (rvalid),
        .writer_addr_i   (addr),
        .writer_we_i     (we),
        .writer_be_i     (be),
        .writer_wdata_i  (wdata),
        .writer_rdata_o  (rdata),
        .reader_axi_req  (axi_req),
        .reader_axi_rsp  (axi_rsp),
        .fifo_empty_o    (empty),
        .fifo_full_o     (full),
        .err_count_o     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count AXI address/data handshakes to catch duplicated or lost beats
    always @(posedge clk) begin
        if (rst_ni) begin
            if (axi_req.aw_valid && axi_rsp.aw_ready) aw_cnt <= aw_cnt + 1;
            if (axi_req.w_valid && axi_rsp.w_ready)   w_cnt  <= w_cnt + 1;
        end
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic obi_write(input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        #1;
        chk("write_gnt", {63'd0, gnt}, 64'd1);
        step();
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic obi_read(input logic [31:0] a, input logic [31:0] exp);
        req = 1'b1; we = 1'b0; addr = a;
        #1;
        chk("read_gnt", {63'd0, gnt}, 64'd1);
        step();
        req = 1'b0; addr = '0;
        chk("read_rvalid", {63'd0, rvalid}, 64'd1);
        chk("read_rdata", {32'd0, rdata}, {32'd0, exp});
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!axi_req.aw_valid && n < 20) begin
            step();
            n++;
        end
        chk("wait_valid_timeout", {63'd0, (n < 20)}, 64'd1);
    endtask

    task automatic drain(input logic [31:0] exp, input logic [1:0] resp);
        wait_valid();
        chk("drain_w_data", {32'd0, axi_req.w.data}, {32'd0, exp});
        chk("drain_w_valid", {63'd0, axi_req.w_valid}, 64'd1);
        axi_rsp.aw_ready = 1'b1; axi_rsp.w_ready = 1'b1;
        step();
        axi_rsp.aw_ready = 1'b0; axi_rsp.w_ready = 1'b0;
        chk("drain_b_ready", {63'd0, axi_req.b_ready}, 64'd1);
        axi_rsp.b_valid = 1'b1; axi_rsp.b.resp = resp;
        step();
        axi_rsp.b_valid = 1'b0; axi_rsp.b.resp = 2'b00;
    endtask

    // Directed stimulus sequence
    initial begin
        rst_ni = 1'b0; testmode = 1'b0; req = 1'b0; addr = '0; we = 1'b0;
        be = 4'hF; wdata = '0; axi_rsp = '0;

        // Reset state
        step(); step();
        chk("rst_rvalid",  {63'd0, rvalid}, 64'd0);
        chk("rst_rdata",   {32'd0, rdata}, 64'd0);
        chk("rst_aw_valid", {63'd0, axi_req.aw_valid}, 64'd0);
        chk("rst_w_valid", {63'd0, axi_req.w_valid}, 64'd0);
        chk("rst_b_ready", {63'd0, axi_req.b_ready}, 64'd0);
        chk("rst_ar_valid", {63'd0, axi_req.ar_valid}, 64'd0);
        chk("rst_r_ready", {63'd0, axi_req.r_ready}, 64'd1);
        chk("rst_empty",   {63'd0, empty}, 64'd1);
        chk("rst_full",    {63'd0, full}, 64'd0);
        chk("rst_err",     {56'd0, err_cnt}, 64'd0);
        rst_ni = 1'b1;
        step();

        // Single word, AXI always ready
        axi_rsp.aw_ready = 1'b1; axi_rsp.w_ready = 1'b1;
        obi_write(32'h0, 32'hDEAD_BEEF);
        chk("t1_rvalid", {63'd0, rvalid}, 64'd1);
        chk("t1_rdata",  {32'd0, rdata}, 64'd0);
        chk("t1_empty",  {63'd0, empty}, 64'd0);
        chk("t1_aw_early", {63'd0, axi_req.aw_valid}, 64'd0);
        step();
        chk("t2_aw_valid", {63'd0, axi_req.aw_valid}, 64'd1);
        chk("t2_w_valid",  {63'd0, axi_req.w_valid}, 64'd1);
        chk("t2_addr",  {32'd0, axi_req.aw.addr}, {32'd0, C_DST});
        chk("t2_len",   {56'd0, axi_req.aw.len}, 64'd0);
        chk("t2_size",  {61'd0, axi_req.aw.size}, 64'd2);
        chk("t2_burst", {62'd0, axi_req.aw.burst}, 64'd1);
        chk("t2_data",  {32'd0, axi_req.w.data}, 64'hDEAD_BEEF);
        chk("t2_strb",  {60'd0, axi_req.w.strb}, 64'hF);
        chk("t2_last",  {63'd0, axi_req.w.last}, 64'd1);
        step();
        axi_rsp.aw_ready = 1'b0; axi_rsp.w_ready = 1'b0;
        chk("t3_b_ready", {63'd0, axi_req.b_ready}, 64'd1);
        chk("t3_aw_valid", {63'd0, axi_req.aw_valid}, 64'd0);
        chk("t3_empty_before_b", {63'd0, empty}, 64'd0);
        axi_rsp.b_valid = 1'b1;
        step();
        axi_rsp.b_valid = 1'b0;
        chk("t4_empty", {63'd0, empty}, 64'd1);
        chk("t4_err",   {56'd0, err_cnt}, 64'd0);
        chk("t4_b_ready", {63'd0, axi_req.b_ready}, 64'd0);

        // Fill and stall with AXI not ready
        for (int i = 0; i < 9; i++) begin
            req = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'hA000_0000 + i;
            #1;
            chk("fill_gnt", {63'd0, gnt}, {63'd0, (i < 8)});
            if (i < 8) step();
        end
        chk("fill_full", {63'd0, full}, 64'd1);
        step();
        chk("stall_rvalid", {63'd0, rvalid}, 64'd0);
        chk("stall_gnt", {63'd0, gnt}, 64'd0);
        step();
        chk("stall_head", {32'd0, axi_req.w.data}, 64'hA000_0000);
        chk("stall_aw_hold", {63'd0, axi_req.aw_valid}, 64'd1);
        axi_rsp.aw_ready = 1'b1; axi_rsp.w_ready = 1'b1;
        step();
        axi_rsp.aw_ready = 1'b0; axi_rsp.w_ready = 1'b0;
        chk("stall_resp_gnt", {63'd0, gnt}, 64'd0);
        axi_rsp.b_valid = 1'b1;
        #1;
        chk("no_bypass_gnt", {63'd0, gnt}, 64'd0);
        step();
        axi_rsp.b_valid = 1'b0;
        #1;
        chk("after_pop_full", {63'd0, full}, 64'd0);
        chk("after_pop_gnt", {63'd0, gnt}, 64'd1);
        step();
        req = 1'b0; we = 1'b0;
        chk("ninth_rvalid", {63'd0, rvalid}, 64'd1);
        for (int k = 1; k < 9; k++) begin
            drain(32'hA000_0000 + k, 2'b00);
        end
        chk("fill_drained_empty", {63'd0, empty}, 64'd1);

        // Split handshakes: AW first, then W first
        obi_write(32'h0, 32'hB000_0000);
        obi_write(32'h0, 32'hB000_0001);
        wait_valid();
        axi_rsp.aw_ready = 1'b1;
        step();
        axi_rsp.aw_ready = 1'b0;
        chk("split0_aw_dropped", {63'd0, axi_req.aw_valid}, 64'd0);
        chk("split0_w_held", {63'd0, axi_req.w_valid}, 64'd1);
        step(); step();
        chk("split0_aw_still_low", {63'd0, axi_req.aw_valid}, 64'd0);
        chk("split0_w_data", {32'd0, axi_req.w.data}, 64'hB000_0000);
        axi_rsp.w_ready = 1'b1;
        step();
        axi_rsp.w_ready = 1'b0;
        chk("split0_b_ready", {63'd0, axi_req.b_ready}, 64'd1);
        chk("split0_w_low", {63'd0, axi_req.w_valid}, 64'd0);
        step();
        chk("split0_no_early_pop", {63'd0, axi_req.w.data}, 64'hB000_0000);
        axi_rsp.b_valid = 1'b1;
        step();
        axi_rsp.b_valid = 1'b0;
        chk("split0_empty", {63'd0, empty}, 64'd0);
        wait_valid();
        chk("split1_w_data", {32'd0, axi_req.w.data}, 64'hB000_0001);
        axi_rsp.w_ready = 1'b1;
        step();
        axi_rsp.w_ready = 1'b0;
        chk("split1_w_dropped", {63'd0, axi_req.w_valid}, 64'd0);
        chk("split1_aw_held", {63'd0, axi_req.aw_valid}, 64'd1);
        step(); step();
        chk("split1_aw_addr", {32'd0, axi_req.aw.addr}, {32'd0, C_DST});
        axi_rsp.aw_ready = 1'b1;
        step();
        axi_rsp.aw_ready = 1'b0;
        chk("split1_b_ready", {63'd0, axi_req.b_ready}, 64'd1);
        axi_rsp.b_valid = 1'b1;
        step();
        axi_rsp.b_valid = 1'b0;
        chk("split1_empty", {63'd0, empty}, 64'd1);

        // Error responses and register reads
        for (int i = 0; i < 3; i++) begin
            obi_write(32'h0, 32'hE000_0000 + i);
            drain(32'hE000_0000 + i, 2'b10);
        end
        chk("err_count3", {56'd0, err_cnt}, 64'd3);
        obi_read(32'h4, 32'd3);
        obi_write(32'h4, 32'hFFFF_FFFF);
        chk("err_write_discard", {63'd0, empty}, 64'd1);
        obi_write(32'h0, 32'hD000_0000);
        obi_write(32'h0, 32'hD000_0001);
        obi_read(32'h0, 32'h0000_0200);

        // Reset in RESP with four queued words
        obi_write(32'h0, 32'hD000_0002);
        obi_write(32'h0, 32'hD000_0003);
        axi_rsp.aw_ready = 1'b1; axi_rsp.w_ready = 1'b1;
        begin
            int n = 0;
            while (!axi_req.b_ready && n < 20) begin
                step();
                n++;
            end
            chk("resp_wait_timeout", {63'd0, (n < 20)}, 64'd1);
        end
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        axi_rsp.aw_ready = 1'b0; axi_rsp.w_ready = 1'b0;
        chk("mid_rst_aw_valid", {63'd0, axi_req.aw_valid}, 64'd0);
        chk("mid_rst_w_valid", {63'd0, axi_req.w_valid}, 64'd0);
        chk("mid_rst_b_ready", {63'd0, axi_req.b_ready}, 64'd0);
        chk("mid_rst_empty", {63'd0, empty}, 64'd1);
        chk("mid_rst_full", {63'd0, full}, 64'd0);
        chk("mid_rst_err", {56'd0, err_cnt}, 64'd0);
        step();
        obi_read(32'h0, 32'h0000_0001);
        obi_write(32'h0, 32'hC0FF_EE00);
        drain(32'hC0FF_EE00, 2'b00);
        chk("resume_empty", {63'd0, empty}, 64'd1);
        chk("aw_handshakes", aw_cnt, 64'd17);
        chk("w_handshakes", w_cnt, 64'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
